// File: rtl/serial_sum_pkg.sv
// Shared types and constants for the serial sum receiver.
// Holds the FSM state encoding, the default frame width and the
// bit-counter width helper used by the top and the counter.
package serial_sum_pkg;

  // Frame width used when the instantiating code does not override WIDTH.
  localparam int SSR_DEFAULT_WIDTH = 8;

  // 2-bit state code; 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  // The counter must be able to represent WIDTH (one past the final bit)
  // so it never wraps inside a frame.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_bit_cnt.sv
// Purpose: bit counter for the serial receiver with clear, enable and terminal count.
// Latency: o_tc is combinational from the registered count (count == WIDTH-1).
// Backpressure: none; the count holds whenever i_en is low.
//
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset (count -> 0)
//   i_clr   - synchronous clear, has priority over i_en
//   i_en    - increment by one
//   o_tc    - high while the count equals WIDTH-1 (next accepted bit is the last)
module serial_bit_cnt
  import serial_sum_pkg::*;
#(
  parameter int WIDTH = SSR_DEFAULT_WIDTH
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int             CW = cnt_width(WIDTH);
  localparam logic [CW-1:0]  TC = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/serial_sum_rx.sv
// Purpose: assembles a LSB-first serial sum (S) plus final carry (COUT) into a parallel word.
// Latency: out_valid rises the cycle after the WIDTH-th accepted bit.
// Backpressure: result held in HOLD until out_valid & out_ready; start/in_valid ignored meanwhile.
//
// Optional feature: define SERIAL_SUM_RX_ERR_EN to enable the sticky protocol
// error flag; otherwise err is tied low.
//
// Ports:
//   CLK, NRST            - clock (rising edge) and asynchronous active-low reset
//   start                - begin a frame while idle
//   rst                  - synchronous abort back to idle (highest priority)
//   in_valid, S, COUT    - serial bit strobe, sum bit, carry (used on final bit only)
//   sum_out, cout_out    - assembled result and captured carry
//   out_valid, out_ready - result handshake
//   busy                 - registered, high while shifting
//   err                  - sticky overrun / start-while-busy flag
module serial_sum_rx
  import serial_sum_pkg::*;
#(
  parameter int WIDTH = SSR_DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             start,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             S,
  input  logic             COUT,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_start_acc;
  logic             w_shift_en;
  logic             w_final;
  logic             w_tc;
  logic             w_cnt_clr;
  logic [WIDTH-1:0] w_shift_nxt;

  // rst is folded into every qualifier so it wins over start/in_valid.
  assign w_start_acc = (r_state == ST_IDLE)  && start    && !rst;
  assign w_shift_en  = (r_state == ST_SHIFT) && in_valid && !rst;
  assign w_final     = w_shift_en && w_tc;
  assign w_cnt_clr   = rst || w_start_acc;

  // New bits enter at the MSB so the first (LSB) bit lands in bit 0 after WIDTH shifts.
  assign w_shift_nxt = {S, r_shift[WIDTH-1:1]};

  serial_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .i_clk   (CLK),
    .i_rst_n (NRST),
    .i_clr   (w_cnt_clr),
    .i_en    (w_shift_en),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start)     w_next = ST_SHIFT;
      ST_SHIFT: if (w_final)   w_next = ST_HOLD;
      ST_HOLD:  if (out_ready) w_next = ST_IDLE;
      default:                 w_next = ST_IDLE;
    endcase
    if (rst) begin
      w_next = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Flags are registered from the next state so they line up with r_state.
      r_busy      <= (w_next == ST_SHIFT);
      r_out_valid <= (w_next == ST_HOLD);

      if (rst || w_start_acc) begin
        r_shift <= '0;
      end else if (w_shift_en) begin
        r_shift <= w_shift_nxt;
      end

      // Result registers are only written on the final bit; abort leaves them alone.
      if (w_final) begin
        r_sum  <= w_shift_nxt;
        r_cout <= COUT;
      end
    end
  end

  assign sum_out   = r_sum;
  assign cout_out  = r_cout;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

`ifdef SERIAL_SUM_RX_ERR_EN
  logic r_err;
  logic w_err_set;

  // Overrun: a bit offered when no frame is being shifted; or a start during a frame.
  assign w_err_set = (in_valid && ((r_state == ST_IDLE) || (r_state == ST_HOLD))) ||
                     (start && (r_state == ST_SHIFT));

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_err <= 1'b0;
    end else if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sum_rx.sv
module tb_serial_sum_rx;

  localparam int W = 8;

`ifdef SERIAL_SUM_RX_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         NRST;
  logic         start;
  logic         rst;
  logic         in_valid;
  logic         S;
  logic         COUT;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         out_valid;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  serial_sum_rx #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .NRST      (NRST),
    .start     (start),
    .rst       (rst),
    .in_valid  (in_valid),
    .S         (S),
    .COUT      (COUT),
    .sum_out   (sum_out),
    .cout_out  (cout_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives start, then WIDTH bits of v (LSB first) with 'gap' idle cycles
  // before each bit. COUT is the inverse of c on non-final bits so a wrong
  // capture point shows up. Returns 1 unit after the final bit's edge.
  task automatic send_bits(input logic [W-1:0] v, input logic c, input int gap);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      repeat (gap) begin
        in_valid = 1'b0;
        S        = 1'($urandom_range(0, 1));
        COUT     = 1'($urandom_range(0, 1));
        tick();
      end
      in_valid = 1'b1;
      S        = v[i];
      COUT     = (i == W - 1) ? c : ~c;
      tick();
    end
    in_valid = 1'b0;
    S        = 1'b0;
    COUT     = 1'b0;
  endtask

  task automatic test_reset();
    NRST = 1'b0; start = 1'b0; rst = 1'b0; in_valid = 1'b0;
    S = 1'b0; COUT = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({sum_out, cout_out, out_valid, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got sum=%h cout=%b vld=%b busy=%b err=%b exp all 0",
               sum_out, cout_out, out_valid, busy, err);
    end
    #3 NRST = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%b vld=%b exp 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_bits(8'hA5, 1'b1, 0);
    checks++;
    if (out_valid !== 1'b1 || sum_out !== 8'hA5 || cout_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got vld=%b sum=%h cout=%b busy=%b exp 1 a5 1 0",
               out_valid, sum_out, cout_out, busy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || sum_out !== 8'hA5 || cout_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_one_cycle got vld=%b sum=%h cout=%b exp 0 a5 1",
               out_valid, sum_out, cout_out);
    end
  endtask

  task automatic test_gaps();
    int busy_bad = 0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      repeat (3) begin
        in_valid = 1'b0;
        S        = 1'($urandom_range(0, 1));
        tick();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
          errors++;
          busy_bad++;
          if (busy_bad < 4)
            $display("FAIL gaps_busy bit=%0d got busy=%b vld=%b exp 1 0", i, busy, out_valid);
        end
      end
      in_valid = 1'b1;
      S        = 1'((8'hA5 >> i) & 1);
      COUT     = (i == W - 1);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sum_out !== 8'hA5 || cout_out !== 1'b1) begin
      errors++;
      $display("FAIL gaps_result got vld=%b sum=%h cout=%b exp 1 a5 1", out_valid, sum_out, cout_out);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_bits(8'h3C, 1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || sum_out !== 8'h3C || cout_out !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d got vld=%b sum=%h cout=%b exp 1 3c 0",
                 k, out_valid, sum_out, cout_out);
      end
      start = 1'b1;
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || sum_out !== 8'h3C) begin
      errors++;
      $display("FAIL hold_sixth got vld=%b sum=%h exp 1 3c", out_valid, sum_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sum_out !== 8'h3C) begin
      errors++;
      $display("FAIL hold_release got vld=%b busy=%b sum=%h exp 0 0 3c", out_valid, busy, sum_out);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle got busy=%b vld=%b exp 0 0", busy, out_valid);
    end
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; S = 1'b1; COUT = 1'b1;
      tick();
    end
    rst = 1'b1; start = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sum_out !== 8'h3C || err !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy=%b vld=%b sum=%h err=%b exp 0 0 3c 0",
               busy, out_valid, sum_out, err);
    end
    send_bits(8'hFF, 1'b0, 0);
    checks++;
    if (out_valid !== 1'b1 || sum_out !== 8'hFF || cout_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_frame got vld=%b sum=%h cout=%b exp 1 ff 0", out_valid, sum_out, cout_out);
    end
    tick();
  endtask

  task automatic test_err();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (err !== ERR_EXP || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_set got err=%b busy=%b exp %b 0", err, busy, ERR_EXP);
    end
    repeat (3) tick();
    checks++;
    if (err !== ERR_EXP) begin
      errors++;
      $display("FAIL err_sticky got %b exp %b", err, ERR_EXP);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b exp 0", err);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; S = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2 NRST = 1'b0;
    #1;
    checks++;
    if ({sum_out, cout_out, out_valid, busy, err} !== '0) begin
      errors++;
      $display("FAIL async_reset got sum=%h cout=%b vld=%b busy=%b err=%b exp all 0",
               sum_out, cout_out, out_valid, busy, err);
    end
    #3 NRST = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL async_idle got busy=%b exp 0", busy);
    end
    out_ready = 1'b1;
    send_bits(8'h01, 1'b1, 0);
    checks++;
    if (out_valid !== 1'b1 || sum_out !== 8'h01 || cout_out !== 1'b1) begin
      errors++;
      $display("FAIL async_next_frame got vld=%b sum=%h cout=%b exp 1 01 1", out_valid, sum_out, cout_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_bits(8'h5A, 1'b0, 0);
    checks++;
    if (sum_out !== 8'h5A || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got sum=%h vld=%b exp 5a 1", sum_out, out_valid);
    end
    tick();
    send_bits(8'hC3, 1'b1, 0);
    checks++;
    if (sum_out !== 8'hC3 || cout_out !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got sum=%h cout=%b vld=%b exp c3 1 1", sum_out, cout_out, out_valid);
    end
    tick();
  endtask

  // Reference: the result is the weighted sum of the bits in arrival order.
  task automatic test_random();
    int          b[W];
    int unsigned exp_sum;
    logic        exp_c;
    int          hold;
    for (int f = 0; f < 20; f++) begin
      exp_sum = 0;
      for (int i = 0; i < W; i++) begin
        b[i]    = $urandom_range(0, 1);
        exp_sum = exp_sum + b[i] * (2 ** i);
      end
      exp_c     = 1'($urandom_range(0, 1));
      hold      = $urandom_range(0, 3);
      out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          tick();
        end
        in_valid = 1'b1;
        S        = (b[i] != 0);
        COUT     = (i == W - 1) ? exp_c : ~exp_c;
        tick();
      end
      in_valid = 1'b0;
      for (int h = 0; h < hold; h++) begin
        checks++;
        if (out_valid !== 1'b1 || sum_out !== W'(exp_sum)) begin
          errors++;
          $display("FAIL rand_hold frame=%0d got vld=%b sum=%h exp 1 %h", f, out_valid, sum_out, W'(exp_sum));
        end
        tick();
      end
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || sum_out !== W'(exp_sum) || cout_out !== exp_c) begin
        errors++;
        $display("FAIL rand_result frame=%0d got vld=%b sum=%h cout=%b exp 1 %h %b",
                 f, out_valid, sum_out, cout_out, W'(exp_sum), exp_c);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_release frame=%0d got vld=%b busy=%b exp 0 0", f, out_valid, busy);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rand_no_err got %b exp 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_abort();
    test_err();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sum_rx.md
SERIAL_SUM_RX -- requirements
Module: serial_sum_rx

Interface
REQ-001 Parameter WIDTH, default 8, number of sum bits per frame (range 2..32).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 NRST  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin a new frame when idle.
REQ-005 rst  input  1  synchronous abort; returns block to IDLE.
REQ-006 in_valid  input  1  S/COUT carry a valid serial bit this cycle.
REQ-007 S  input  1  serial sum bit, LSB first.
REQ-008 COUT  input  1  carry bit; sampled only with the final (WIDTH-th) bit.
REQ-009 sum_out  output  WIDTH  assembled parallel sum.
REQ-010 cout_out  output  1  captured final carry.
REQ-011 out_valid  output  1  sum_out/cout_out valid; held until accepted.
REQ-012 out_ready  input  1  downstream accepts result when high with out_valid.
REQ-013 busy  output  1  high in SHIFT state.
REQ-014 err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-015 FSM states: IDLE, SHIFT, HOLD; encoded as a 2-bit value, with the unused code recovering to IDLE.
REQ-016 IDLE: start=1 -> SHIFT next cycle; bit counter cleared to 0; shift register cleared.
REQ-017 SHIFT: each cycle with in_valid=1 shifts S into the register MSB end (shift right), counter +1.
REQ-018 SHIFT: in_valid=0 -> hold register and counter; no timeout.
REQ-019 The bit accepted with counter=WIDTH-1 is the final bit; COUT is captured on that same edge, along with the transfer to sum_out.
REQ-020 Final bit -> HOLD; out_valid=1 from the cycle after the final bit edge (latency 1).
REQ-021 HOLD: out_valid and out_ready both high -> IDLE next cycle; out_valid drops; sum_out/cout_out keep their last value.
REQ-022 HOLD with out_ready=0: hold all outputs stable; start is ignored.
REQ-023 start in SHIFT is ignored; the frame continues.
REQ-024 rst=1 in any state -> IDLE next cycle; out_valid=0, busy=0, counter=0; sum_out/cout_out unchanged; rst has priority over start, in_valid and out_ready.
REQ-025 Counter width is $clog2(WIDTH)+1; the counter never wraps inside a frame.
REQ-026 busy is registered and equals (state==SHIFT).

Reset
REQ-027 NRST low: state=IDLE; counter=0; shift register=0; sum_out=0; cout_out=0; out_valid=0; busy=0; err=0.
REQ-028 NRST deassertion mid-frame discards any partial frame; the first cycle after reset starts in IDLE.

Configuration
REQ-029 Macro SERIAL_SUM_RX_ERR_EN defined: err sets on in_valid=1 in IDLE or HOLD (overrun), or on start in SHIFT; err clears only on NRST or rst.
REQ-030 Macro undefined: err is tied to 0 and no error logic is synthesized; all other behaviour is identical.

Structure
REQ-031 Shared package serial_sum_pkg holds the state typedef (IDLE/SHIFT/HOLD codes) and the default WIDTH constant.
REQ-032 One sub-module, serial_bit_cnt: a bit counter with clear, enable, and terminal-count output (count==WIDTH-1), instantiated once.

Verification
REQ-033 WIDTH=8, start, then bits 1,0,1,0,0,1,0,1 on consecutive cycles with COUT=1 on the 8th bit, out_ready=1 -> sum_out=0xA5, cout_out=1, out_valid high exactly one cycle, starting the cycle after the 8th bit.
REQ-034 Same frame with in_valid gaps of 3 cycles between bits -> same result; busy high throughout the gaps.
REQ-035 Frame 0x3C completed with out_ready=0 for 5 cycles, then 1 -> out_valid and sum_out=0x3C stable for 6 cycles; return to IDLE after the handshake.
REQ-036 rst asserted after 4 bits, then a full frame for 0xFF with COUT=0 -> sum_out=0xFF, cout_out=0; no stale bits.
REQ-037 With SERIAL_SUM_RX_ERR_EN: in_valid=1 in IDLE -> err=1 the next cycle and remains set; rst -> err=0. Without the macro, the same stimulus -> err stays 0.
REQ-038 NRST pulsed low mid-frame -> all outputs 0 asynchronously; a subsequent frame 0x01 -> sum_out=0x01.
